i2c_target_mem: RTL



---
 rtl/i2c_pkg.sv | 21 ++
 rtl/i2c_line_sync.sv | 29 ++
 rtl/i2c_target_mem.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/i2c_pkg.sv
// Shared definitions for the I2C controller/target pair: FSM state encoding,
// byte size and the default device address.
package i2c_pkg;

    typedef enum logic [3:0] {
        ST_IDLE      = 4'd0,
        ST_DEV_ADDR  = 4'd1,
        ST_DEV_ACK   = 4'd2,
        ST_MEM_ADDR  = 4'd3,
        ST_MEM_ACK   = 4'd4,
        ST_WR_DATA   = 4'd5,
        ST_WR_ACK    = 4'd6,
        ST_RD_DATA   = 4'd7,
        ST_RD_ACK    = 4'd8,
        ST_WAIT_STOP = 4'd9
    } i2c_state_t;

    localparam int CHUNK_SIZE = 8;
    localparam logic [6:0] SLV_ADDR_DEFAULT = 7'b101_1001;

endpackage

// File: rtl/i2c_line_sync.sv
// Two-flop synchronizer plus a registered edge detector for one I2C line.
// level/rise/fall all appear 3 clk after the pin changes.
module i2c_line_sync (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [1:0] sync;

    // Idle bus is high, so reset to 1 to avoid a spurious edge after reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync  <= 2'b11;
            level <= 1'b1;
            rise  <= 1'b0;
            fall  <= 1'b0;
        end else begin
            sync  <= {sync[0], din};
            level <= sync[1];
            rise  <= sync[1] & ~level;
            fall  <= ~sync[1] & level;
        end
    end

endmodule

// File: rtl/i2c_target_mem.sv
// I2C target with a small register memory: one-byte write or read per
// transaction, addressed by a one-byte memory address after the device address.
module i2c_target_mem
    import i2c_pkg::*;
#(
    parameter int DATAWIDTH     = 8,
    parameter int ADDRWIDTH     = 6,
    parameter int SLV_ADDR_SIZE = 7,
    parameter logic [SLV_ADDR_SIZE-1:0] SLV_ADDR_PARAM = SLV_ADDR_DEFAULT
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 scl,
    inout  wire                  sda,
    input  logic [ADDRWIDTH-1:0] dbg_addr,
    output logic [DATAWIDTH-1:0] dbg_data,
    output logic                 wr_valid,
    output logic [ADDRWIDTH-1:0] wr_addr,
    output logic [DATAWIDTH-1:0] wr_data,
    output logic                 busy,
    output logic [3:0]           dbg_state
);

    localparam int DEPTH = 2 ** ADDRWIDTH;
    localparam logic [2:0] BIT_TOP = 3'(CHUNK_SIZE - 1);

    logic scl_level, scl_rise, scl_fall;
    logic sda_level, sda_rise, sda_fall;

    i2c_line_sync u_scl_sync (
        .clk   (clk),
        .reset (reset),
        .din   (scl),
        .level (scl_level),
        .rise  (scl_rise),
        .fall  (scl_fall)
    );

    i2c_line_sync u_sda_sync (
        .clk   (clk),
        .reset (reset),
        .din   (sda),
        .level (sda_level),
        .rise  (sda_rise),
        .fall  (sda_fall)
    );

    i2c_state_t             state, state_n;
    logic [2:0]             bit_cnt, bit_cnt_n;
    logic [DATAWIDTH-1:0]   shreg, shreg_n;
    logic                   rw, rw_n;
    logic [ADDRWIDTH-1:0]   mem_addr, mem_addr_n;
    logic                   sda_oe, sda_oe_n;
    logic                   mem_we;
    logic [DATAWIDTH-1:0]   mem [DEPTH];

    logic                   start_det, stop_det, last_bit;
    logic [DATAWIDTH-1:0]   byte_in;

    assign start_det = sda_fall & scl_level;
    assign stop_det  = sda_rise & scl_level;
    assign last_bit  = (bit_cnt == 3'd0);
    assign byte_in   = {shreg[DATAWIDTH-2:0], sda_level};

    assign sda       = sda_oe ? 1'b0 : 1'bz;
    assign dbg_data  = mem[dbg_addr];
    assign busy      = (state != ST_IDLE);
    assign dbg_state = state;

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ST_IDLE;
            bit_cnt  <= BIT_TOP;
            shreg    <= '0;
            rw       <= 1'b0;
            mem_addr <= '0;
            sda_oe   <= 1'b0;
            wr_valid <= 1'b0;
            wr_addr  <= '0;
            wr_data  <= '0;
        end else begin
            state    <= state_n;
            bit_cnt  <= bit_cnt_n;
            shreg    <= shreg_n;
            rw       <= rw_n;
            mem_addr <= mem_addr_n;
            sda_oe   <= sda_oe_n;
            wr_valid <= mem_we;
            if (mem_we) begin
                wr_addr <= mem_addr;
                wr_data <= byte_in;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (mem_we) begin
            mem[mem_addr] <= byte_in;
        end
    end

    // ACK states drive low on the first SCL fall and release on the second,
    // so sda_oe itself tells which half of the ACK bit we are in.
    always_comb begin
        state_n    = state;
        bit_cnt_n  = bit_cnt;
        shreg_n    = shreg;
        rw_n       = rw;
        mem_addr_n = mem_addr;
        sda_oe_n   = sda_oe;
        mem_we     = 1'b0;

        if (start_det) begin
            state_n   = ST_DEV_ADDR;
            bit_cnt_n = BIT_TOP;
            sda_oe_n  = 1'b0;
        end else if (stop_det) begin
            state_n  = ST_IDLE;
            sda_oe_n = 1'b0;
        end else begin
            case (state)
                ST_DEV_ADDR: if (scl_rise) begin
                    shreg_n   = byte_in;
                    bit_cnt_n = bit_cnt - 3'd1;
                    if (last_bit) begin
                        if (byte_in[DATAWIDTH-1 -: SLV_ADDR_SIZE] == SLV_ADDR_PARAM) begin
                            rw_n    = byte_in[0];
                            state_n = ST_DEV_ACK;
                        end else begin
                            state_n = ST_WAIT_STOP;
                        end
                    end
                end
                ST_DEV_ACK: if (scl_fall) begin
                    sda_oe_n = ~sda_oe;
                    if (sda_oe) begin
                        state_n   = ST_MEM_ADDR;
                        bit_cnt_n = BIT_TOP;
                    end
                end
                ST_MEM_ADDR: if (scl_rise) begin
                    shreg_n   = byte_in;
                    bit_cnt_n = bit_cnt - 3'd1;
                    if (last_bit) begin
                        mem_addr_n = byte_in[ADDRWIDTH-1:0];
                        state_n    = ST_MEM_ACK;
                    end
                end
                ST_MEM_ACK: if (scl_fall) begin
                    if (!sda_oe) begin
                        sda_oe_n = 1'b1;
                    end else begin
                        bit_cnt_n = BIT_TOP;
                        if (rw) begin
                            shreg_n  = mem[mem_addr];
                            sda_oe_n = ~mem[mem_addr][DATAWIDTH-1];
                            state_n  = ST_RD_DATA;
                        end else begin
                            sda_oe_n = 1'b0;
                            state_n  = ST_WR_DATA;
                        end
                    end
                end
                ST_WR_DATA: if (scl_rise) begin
                    shreg_n   = byte_in;
                    bit_cnt_n = bit_cnt - 3'd1;
                    if (last_bit) begin
                        mem_we  = 1'b1;
                        state_n = ST_WR_ACK;
                    end
                end
                ST_WR_ACK: if (scl_fall) begin
                    sda_oe_n = ~sda_oe;
                    if (sda_oe) state_n = ST_WAIT_STOP;
                end
                // Each SCL fall moves to the next bit; the fall after bit 0 frees the line.
                ST_RD_DATA: if (scl_fall) begin
                    if (last_bit) begin
                        sda_oe_n = 1'b0;
                        state_n  = ST_RD_ACK;
                    end else begin
                        shreg_n   = {shreg[DATAWIDTH-2:0], 1'b0};
                        sda_oe_n  = ~shreg[DATAWIDTH-2];
                        bit_cnt_n = bit_cnt - 3'd1;
                    end
                end
                ST_RD_ACK: if (scl_rise) begin
                    state_n = ST_WAIT_STOP;
                end
                default: begin
                    sda_oe_n = 1'b0;
                end
            endcase
        end
    end

endmodule
